lsu_dmem_port: RTL and testbench

- Initiator side of the data-memory interface: the pipeline MEM stage issues load/store requests here, and this block drives the byte-addressed data memory port.
- Address, port direction and access size follow the memory's conventions: access size 0 = byte, 1 = half, 2 = word; read-write 1 = store, 0 = load; memory reads are combinational, memory writes happen on the clock edge.
- Buffers requests in an in-order FIFO, checks range and alignment, and returns one registered, sign- or zero-extended response per request.

---
 rtl/lsu_dmem_port.sv | 172 +++++++++++++++++
 tb/tb_lsu_dmem_port.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_port.sv
// Load/store initiator for the byte-addressed data memory: queues MEM-stage requests
// in order, range/alignment checks them, and returns one registered extended response each.
module lsu_dmem_port #(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int          SIZE_BYTES  = 232,
    parameter int          CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_we,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fifo_addr_r  [DEPTH];
    logic          fifo_we_r    [DEPTH];
    logic [1:0]    fifo_size_r  [DEPTH];
    logic          fifo_uns_r   [DEPTH];
    logic [31:0]   fifo_wdata_r [DEPTH];
    logic          fifo_err_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          fire_s;
    logic [31:0]   head_addr_s;
    logic          head_we_s;
    logic [1:0]    head_size_s;
    logic          head_uns_s;
    logic [31:0]   head_wdata_s;
    logic          head_err_s;

    // Reject reserved sizes, misaligned accesses and anything not fully inside the window;
    // the end address is formed in 33 bits so accesses near 2^32 cannot wrap back in.
    function automatic logic req_err_f(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] end_addr;
        logic [32:0] limit;
        logic        misalign;
        end_addr = {1'b0, addr} + (33'd1 << size);
        limit    = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES);
        misalign = (CHECK_ALIGN != 0) &&
                   (((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00)));
        return (size == 2'd3) || misalign || (addr < BASE_ADDR) || (end_addr > limit);
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [31:0] d, input logic [1:0] size,
                                               input logic uns);
        logic [31:0] r;
        case (size)
            2'd0:    r = {{24{~uns & d[7]}}, d[7:0]};
            2'd1:    r = {{16{~uns & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign full_s       = (count_r == CW'(DEPTH));
    assign empty_s      = (count_r == {CW{1'b0}});
    assign req_ready    = !full_s && rst_n;
    assign push_s       = req_valid && req_ready;
    assign fire_s       = !empty_s && (!resp_valid || resp_ready);
    assign head_addr_s  = fifo_addr_r[rd_ptr_r];
    assign head_we_s    = fifo_we_r[rd_ptr_r];
    assign head_size_s  = fifo_size_r[rd_ptr_r];
    assign head_uns_s   = fifo_uns_r[rd_ptr_r];
    assign head_wdata_s = fifo_wdata_r[rd_ptr_r];
    assign head_err_s   = fifo_err_r[rd_ptr_r];

    // Memory port driven straight from the FIFO head; a write strobes only on the issuing cycle.
    always_comb begin
        mem_read_write = 1'b0;
        if (empty_s) begin
            mem_address     = 32'h0;
            mem_access_size = 2'd0;
            mem_data_in     = 32'h0;
        end else begin
            mem_address     = head_addr_s;
            mem_access_size = head_size_s;
            mem_data_in     = head_wdata_s;
        end
        if (fire_s && head_we_s && !head_err_s) begin
            mem_read_write = 1'b1;
        end else begin
            mem_read_write = 1'b0;
        end
    end

    // FIFO entry storage, written at the tail on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i]  <= 32'h0;
                fifo_we_r[i]    <= 1'b0;
                fifo_size_r[i]  <= 2'd0;
                fifo_uns_r[i]   <= 1'b0;
                fifo_wdata_r[i] <= 32'h0;
                fifo_err_r[i]   <= 1'b0;
            end
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r]  <= req_addr;
            fifo_we_r[wr_ptr_r]    <= req_we;
            fifo_size_r[wr_ptr_r]  <= req_size;
            fifo_uns_r[wr_ptr_r]   <= req_unsigned;
            fifo_wdata_r[wr_ptr_r] <= req_wdata;
            fifo_err_r[wr_ptr_r]   <= req_err_f(req_addr, req_size);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, fire_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response slot: loads on issue, clears once consumed, otherwise holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
        end else if (fire_s) begin
            resp_valid <= 1'b1;
            resp_err   <= head_err_s;
            resp_we    <= head_we_s;
            if (head_err_s || head_we_s) begin
                resp_rdata <= 32'h0;
            end else begin
                resp_rdata <= load_ext_f(mem_data_out, head_size_s, head_uns_s);
            end
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: bench-side byte memory, a transaction-level queue model checked
// every cycle, directed literal cases, then randomized traffic.
module tb_lsu_dmem_port;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] BASE       = 32'h01000000;
    localparam int          SIZE_BYTES = 232;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_we;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    lsu_dmem_port #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .SIZE_BYTES(SIZE_BYTES), .CHECK_ALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_we(resp_we),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        if (i == 0) return 8'h01;
        if (i < 4) return 8'h00;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Bench data memory: combinational little-endian read, write on the rising edge.
    logic [7:0] bmem [256];
    logic [7:0] i0, i1, i2, i3;
    int         wr_cnt = 0;
    logic [1:0] last_wr_size = 2'd0;
    assign i0 = mem_address[7:0];
    assign i1 = i0 + 8'd1;
    assign i2 = i0 + 8'd2;
    assign i3 = i0 + 8'd3;
    assign mem_data_out = {bmem[i3], bmem[i2], bmem[i1], bmem[i0]};

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_read_write) begin
                for (int b = 0; b < (1 << mem_access_size); b++)
                    bmem[8'(mem_address[7:0] + 8'(b))] = mem_data_in[8*b +: 8];
                wr_cnt++;
                last_wr_size = mem_access_size;
            end
        end
    end

    // Transaction-level reference: a queue of pending requests plus one response slot.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    req_t        q[$];
    logic [7:0]  rmem [256];
    logic        rv_m = 1'b0;
    logic [31:0] rd_m = 32'h0;
    logic        err_m = 1'b0;
    logic        we_m = 1'b0;
    int          exp_writes = 0;
    int          accepted = 0;

    function automatic logic calc_err(input logic [31:0] a, input logic [1:0] s);
        longint nb = longint'(1) << s;
        longint la = longint'(a);
        if (s == 2'd3) return 1'b1;
        if ((la % nb) != 0) return 1'b1;
        if (la < longint'(BASE) || la + nb > longint'(BASE) + SIZE_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] read_ref(input logic [31:0] a, input logic [1:0] s,
                                             input logic u);
        int     idx = int'(a - BASE);
        int     nb = 1 << s;
        longint v = 0;
        for (int b = 0; b < nb; b++) v = v + (longint'(rmem[idx + b]) << (8 * b));
        if (!u && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = init_byte(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                rv_m = 1'b0;
            end else begin
                bit   fire;
                bit   push;
                req_t h;
                req_t n;
                fire = (q.size() > 0) && (!rv_m || resp_ready);
                push = req_valid && (q.size() < DEPTH);
                if (fire) begin
                    h = q.pop_front();
                    rv_m  = 1'b1;
                    err_m = h.err;
                    we_m  = h.we;
                    rd_m  = (h.err || h.we) ? 32'h0 : read_ref(h.addr, h.size, h.uns);
                    if (h.we && !h.err) begin
                        for (int b = 0; b < (1 << h.size); b++)
                            rmem[int'(h.addr - BASE) + b] = h.wdata[8*b +: 8];
                        exp_writes++;
                    end
                end else if (rv_m && resp_ready) begin
                    rv_m = 1'b0;
                end
                if (push) begin
                    n.addr = req_addr; n.we = req_we; n.size = req_size;
                    n.uns = req_unsigned; n.wdata = req_wdata;
                    n.err = calc_err(req_addr, req_size);
                    q.push_back(n);
                    accepted++;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_resp_valid", resp_valid, 1'b0);
                chk("rst_req_ready", req_ready, 1'b0);
                chk("rst_mem_rw", mem_read_write, 1'b0);
            end else begin
                bit pf;
                chk("req_ready", req_ready, q.size() < DEPTH);
                chk("resp_valid", resp_valid, rv_m);
                if (rv_m) begin
                    chk("resp_rdata", resp_rdata, rd_m);
                    chk("resp_err", resp_err, err_m);
                    chk("resp_we", resp_we, we_m);
                end
                pf = (q.size() > 0) && (!rv_m || resp_ready);
                if (q.size() > 0) begin
                    chk("mem_rw", mem_read_write, pf && q[0].we && !q[0].err);
                    chk("mem_address", mem_address, q[0].addr);
                    chk("mem_size", mem_access_size, q[0].size);
                    chk("mem_data_in", mem_data_in, q[0].wdata);
                end else begin
                    chk("mem_rw_idle", mem_read_write, 1'b0);
                    chk("mem_address_idle", mem_address, 32'h0);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic we, input logic [1:0] s,
                        input logic u, input logic [31:0] d);
        @(posedge clk); #1;
        req_addr = a; req_we = we; req_size = s; req_unsigned = u; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input string nm, input logic [31:0] er, input logic ee,
                            output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk({nm, "_valid"}, resp_valid, 1'b1);
        chk({nm, "_rdata"}, resp_rdata, er);
        chk({nm, "_err"}, resp_err, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int w0;
        int a0;
        int n;
        int bad;
        logic [31:0] wd;
        logic [31:0] ref_word;

        @(negedge clk);
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_resp_err", resp_err, 1'b0);
        chk("reset_resp_we", resp_we, 1'b0);
        chk("reset_mem_rw", mem_read_write, 1'b0);
        @(negedge clk); #1 rst_n = 1'b1;

        send(BASE, 1'b0, 2'd2, 1'b0, 32'h0);
        get_resp("lw0", 32'h00000001, 1'b0, lat);
        chk("lw0_latency", lat, 2);

        w0 = wr_cnt;
        send(BASE + 32'd5, 1'b1, 2'd0, 1'b0, 32'hFFFFFF80);
        get_resp("sb", 32'h0, 1'b0, lat);
        chk("sb_writes", wr_cnt - w0, 1);
        chk("sb_size", last_wr_size, 2'd0);
        send(BASE + 32'd5, 1'b0, 2'd0, 1'b0, 32'h0);
        get_resp("lb", 32'hFFFFFF80, 1'b0, lat);
        send(BASE + 32'd5, 1'b0, 2'd0, 1'b1, 32'h0);
        get_resp("lbu", 32'h00000080, 1'b0, lat);

        send(BASE + 32'hA, 1'b1, 2'd1, 1'b0, 32'h00008001);
        get_resp("sh", 32'h0, 1'b0, lat);
        send(BASE + 32'hA, 1'b0, 2'd1, 1'b0, 32'h0);
        get_resp("lh", 32'hFFFF8001, 1'b0, lat);
        send(BASE + 32'hA, 1'b0, 2'd1, 1'b1, 32'h0);
        get_resp("lhu", 32'h00008001, 1'b0, lat);
        send(BASE + 32'd2, 1'b0, 2'd2, 1'b0, 32'h0);
        get_resp("lw_misalign", 32'h0, 1'b1, lat);

        w0 = wr_cnt;
        send(32'h00FFFFFC, 1'b0, 2'd2, 1'b0, 32'h0);
        get_resp("lw_below", 32'h0, 1'b1, lat);
        send(32'h010000E8, 1'b1, 2'd2, 1'b0, 32'h12345678);
        get_resp("sw_above", 32'h0, 1'b1, lat);
        send(BASE + 32'h20, 1'b1, 2'd3, 1'b0, 32'h12345678);
        get_resp("size3", 32'h0, 1'b1, lat);
        send(32'h010000E4, 1'b0, 2'd2, 1'b0, 32'h0);
        get_resp("lw_last", 32'h6E4924FF, 1'b0, lat);
        chk("range_no_writes", wr_cnt - w0, 0);

        // Backpressure: one response held plus a full FIFO.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        a0 = accepted;
        for (int i = 0; i < 8; i++) begin
            req_addr = BASE + 32'h10 + 32'(4 * i); req_we = 1'b0; req_size = 2'd2;
            req_unsigned = 1'b0; req_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_accepted", accepted - a0, DEPTH + 1);
        chk("bp_req_ready", req_ready, 1'b0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("bp_drain", n, DEPTH + 1);

        // Reset with three stores queued behind a held load.
        resp_ready = 1'b0;
        send(BASE, 1'b0, 2'd2, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            send(BASE + 32'h40 + 32'(4 * i), 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        @(negedge clk); #1;
        resp_ready = 1'b1;
        #1 chk("pre_reset_mem_rw", mem_read_write, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_mem_rw", mem_read_write, 1'b0);
        @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_resp_valid", resp_valid, 1'b0);
        chk("post_reset_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wd = {bmem[67 + 4*i], bmem[66 + 4*i], bmem[65 + 4*i], bmem[64 + 4*i]};
            ref_word = {init_byte(67 + 4*i), init_byte(66 + 4*i), init_byte(65 + 4*i),
                        init_byte(64 + 4*i)};
            chk("reset_store_dropped", wd, ref_word);
        end

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            int r;
            @(posedge clk); #1;
            r = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            if (r == 0) req_addr = BASE - 32'($urandom_range(1, 8));
            else if (r == 1) req_addr = BASE + 32'(SIZE_BYTES) - 32'($urandom_range(0, 4));
            else req_addr = BASE + 32'($urandom_range(0, SIZE_BYTES - 1));
            if (r >= 6) req_addr[1:0] = 2'b00;
            req_size = (r == 2) ? 2'd3 : 2'($urandom_range(0, 2));
            req_we = 1'($urandom_range(0, 1));
            req_unsigned = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < SIZE_BYTES; i++) if (bmem[i] !== rmem[i]) bad++;
        chk("final_memory_mismatches", bad, 0);
        chk("final_write_count", wr_cnt, exp_writes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
